// File: rtl/v60_wb_arbiter_if.sv
// rtl/v60_wb_arbiter_if.sv - writeback arbiter source handshakes and register-file write port
//
// Purpose: bundles the ALU, load and LDM source handshakes together with the
// register-file write port driven by v60_wb_arbiter.
//   slave  modport : arbiter side (takes valid/data in, drives ready, status and write port)
//   master modport : environment side (drives sources, observes ready, status and write port)
// Signals:
//   alu_valid/alu_ready/alu_waddr/alu_wdata     single-cycle ALU result
//   mem_valid/mem_ready/mem_waddr/mem_wdata     memory-load result
//   ldm_start/ldm_mask                          multi-register load launch
//   ldm_dvalid/ldm_dready/ldm_data              multi-register load data stream
//   ldm_busy/ldm_done/ldm_count                 multi-register load status
//   waddr/wdata/wen                             register-file write port
interface v60_wb_arbiter_if #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
);
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_waddr;
    logic [DATA_W-1:0]   alu_wdata;

    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                ldm_start;
    logic [NUM_REGS-1:0] ldm_mask;
    logic                ldm_dvalid;
    logic                ldm_dready;
    logic [DATA_W-1:0]   ldm_data;
    logic                ldm_busy;
    logic                ldm_done;
    logic [5:0]          ldm_count;

    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                wen;

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  mem_valid, mem_waddr, mem_wdata,
        input  ldm_start, ldm_mask, ldm_dvalid, ldm_data,
        output alu_ready, mem_ready, ldm_dready,
        output ldm_busy, ldm_done, ldm_count,
        output waddr, wdata, wen
    );

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output mem_valid, mem_waddr, mem_wdata,
        output ldm_start, ldm_mask, ldm_dvalid, ldm_data,
        input  alu_ready, mem_ready, ldm_dready,
        input  ldm_busy, ldm_done, ldm_count,
        input  waddr, wdata, wen
    );
endinterface

// File: rtl/v60_wb_arbiter.sv
// rtl/v60_wb_arbiter.sv - V60 writeback arbiter owning the register-file write port
//
// Purpose: merges ALU results, memory-load results and LDM multi-register
// load sequences into at most one register write per cycle. An accepted beat
// is written exactly one cycle later on the registered write port.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  v60_wb_arbiter_if slave modport (source handshakes, LDM status, write port)
module v60_wb_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    v60_wb_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LDM  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [5:0]          count_q, count_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wen_q, wen_d;

    logic [ADDR_W-1:0]   target;
    logic [NUM_REGS-1:0] mask_after_beat;

    // Lowest set bit of the latched mask picks the next LDM destination.
    always_comb begin
        target = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                target = ADDR_W'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit, i.e. the register just written.
    assign mask_after_beat = mask_q & (mask_q - NUM_REGS'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            count_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        count_d        = count_q;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        wen_d          = 1'b0;
        bus.alu_ready  = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.ldm_dready = 1'b0;

        case (state_q)
            IDLE: begin
                // Loads win; an ALU result waits while a load is offered.
                bus.mem_ready = 1'b1;
                bus.alu_ready = !bus.mem_valid;
                if (bus.mem_valid) begin
                    wen_d   = 1'b1;
                    waddr_d = bus.mem_waddr;
                    wdata_d = bus.mem_wdata;
                end else if (bus.alu_valid) begin
                    wen_d   = 1'b1;
                    waddr_d = bus.alu_waddr;
                    wdata_d = bus.alu_wdata;
                end
                // A beat accepted alongside the start still lands before any LDM write.
                if (bus.ldm_start) begin
                    mask_d  = bus.ldm_mask;
                    count_d = '0;
                    state_d = LDM;
                end
            end
            LDM: begin
                // An empty mask accepts no data and finishes straight away.
                bus.ldm_dready = (mask_q != '0);
                if (mask_q == '0) begin
                    state_d = DONE;
                end else if (bus.ldm_dvalid) begin
                    wen_d   = 1'b1;
                    waddr_d = target;
                    wdata_d = bus.ldm_data;
                    mask_d  = mask_after_beat;
                    count_d = count_q + 6'd1;
                    if (mask_after_beat == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.wen       = wen_q;
    assign bus.ldm_busy  = (state_q != IDLE);
    assign bus.ldm_done  = (state_q == DONE);
    assign bus.ldm_count = count_q;

endmodule

// File: tb/tb_v60_wb_arbiter.sv
// tb/tb_v60_wb_arbiter.sv - self-checking bench for v60_wb_arbiter
module tb_v60_wb_arbiter;
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    v60_wb_arbiter_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    v60_wb_arbiter #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_waddr  = '0;
        bus.alu_wdata  = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_waddr  = '0;
        bus.mem_wdata  = '0;
        bus.ldm_start  = 1'b0;
        bus.ldm_mask   = '0;
        bus.ldm_dvalid = 1'b0;
        bus.ldm_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL rst_wen: got %0h want 0", bus.wen); end
        checks++; if (bus.waddr !== '0) begin failures++; $display("FAIL rst_waddr: got %0h want 0", bus.waddr); end
        checks++; if (bus.wdata !== '0) begin failures++; $display("FAIL rst_wdata: got %0h want 0", bus.wdata); end
        checks++; if (bus.ldm_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0h want 0", bus.ldm_busy); end
        checks++; if (bus.ldm_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0h want 0", bus.ldm_done); end
        checks++; if (bus.ldm_count !== 6'd0) begin failures++; $display("FAIL rst_count: got %0h want 0", bus.ldm_count); end
        rst = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 5'd9;
        bus.alu_wdata = 32'h0000_55AA;
        tick();
        checks++; if (bus.wen !== 1'b1) begin failures++; $display("FAIL pre_rst_wen: got %0h want 1", bus.wen); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL async_rst_wen: got %0h want 0", bus.wen); end
        checks++; if (bus.waddr !== '0) begin failures++; $display("FAIL async_rst_waddr: got %0h want 0", bus.waddr); end
        checks++; if (bus.ldm_busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy: got %0h want 0", bus.ldm_busy); end
        #1 rst = 1'b0;
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd9 || bus.wdata !== 32'h0000_55AA) begin
            failures++; $display("FAIL post_rst_write: got wen=%0h waddr=%0h wdata=%0h want 1/9/55aa", bus.wen, bus.waddr, bus.wdata);
        end
        bus.alu_valid = 1'b0;
        tick();
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL post_rst_idle_wen: got %0h want 0", bus.wen); end
    endtask

    task automatic test_alu_single();
        idle_inputs();
        bus.alu_valid = 1'b1;
        bus.alu_waddr = 5'd3;
        bus.alu_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready: got %0h want 1", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL alu_write: got wen=%0h waddr=%0h wdata=%0h want 1/3/deadbeef", bus.wen, bus.waddr, bus.wdata);
        end
        tick();
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL alu_after_wen: got %0h want 0", bus.wen); end
    endtask

    task automatic test_priority();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_waddr = 5'd4; bus.alu_wdata = 32'h1111;
        bus.mem_valid = 1'b1; bus.mem_waddr = 5'd7; bus.mem_wdata = 32'h2222;
        #1;
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            failures++; $display("FAIL prio_ready: got mem=%0h alu=%0h want 1/0", bus.mem_ready, bus.alu_ready);
        end
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd7 || bus.wdata !== 32'h2222) begin
            failures++; $display("FAIL prio_mem_write: got wen=%0h waddr=%0h wdata=%0h want 1/7/2222", bus.wen, bus.waddr, bus.wdata);
        end
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL prio_alu_ready: got %0h want 1", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd4 || bus.wdata !== 32'h1111) begin
            failures++; $display("FAIL prio_alu_write: got wen=%0h waddr=%0h wdata=%0h want 1/4/1111", bus.wen, bus.waddr, bus.wdata);
        end
        tick();
        checks++; if (bus.wen !== 1'b0) begin failures++; $display("FAIL prio_after_wen: got %0h want 0", bus.wen); end
    endtask

    task automatic test_ldm_stall();
        idle_inputs();
        bus.ldm_start = 1'b1; bus.ldm_mask = 32'h0000_8005;
        bus.alu_valid = 1'b1; bus.alu_waddr = 5'd6; bus.alu_wdata = 32'h66;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL ldm_start_alu_ready: got %0h want 1", bus.alu_ready); end
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd6 || bus.wdata !== 32'h66) begin
            failures++; $display("FAIL ldm_start_alu_write: got wen=%0h waddr=%0h wdata=%0h want 1/6/66", bus.wen, bus.waddr, bus.wdata);
        end
        checks++; if (bus.ldm_busy !== 1'b1 || bus.ldm_count !== 6'd0) begin
            failures++; $display("FAIL ldm_enter: got busy=%0h count=%0d want 1/0", bus.ldm_busy, bus.ldm_count);
        end
        bus.ldm_start = 1'b0; bus.ldm_dvalid = 1'b1; bus.ldm_data = 32'hA;
        #1;
        checks++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.ldm_dready !== 1'b1) begin
            failures++; $display("FAIL ldm_ready: got alu=%0h mem=%0h d=%0h want 0/0/1", bus.alu_ready, bus.mem_ready, bus.ldm_dready);
        end
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd0 || bus.wdata !== 32'hA || bus.ldm_done !== 1'b0) begin
            failures++; $display("FAIL ldm_w0: got wen=%0h waddr=%0h wdata=%0h done=%0h want 1/0/a/0", bus.wen, bus.waddr, bus.wdata, bus.ldm_done);
        end
        bus.ldm_dvalid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b0) begin failures++; $display("FAIL ldm_stall_alu_ready: got %0h want 0", bus.alu_ready); end
        tick();
        checks++; if (bus.wen !== 1'b0 || bus.ldm_busy !== 1'b1) begin
            failures++; $display("FAIL ldm_stall: got wen=%0h busy=%0h want 0/1", bus.wen, bus.ldm_busy);
        end
        bus.ldm_dvalid = 1'b1; bus.ldm_data = 32'hB;
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd2 || bus.wdata !== 32'hB) begin
            failures++; $display("FAIL ldm_w2: got wen=%0h waddr=%0h wdata=%0h want 1/2/b", bus.wen, bus.waddr, bus.wdata);
        end
        bus.ldm_data = 32'hC;
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd15 || bus.wdata !== 32'hC) begin
            failures++; $display("FAIL ldm_w15: got wen=%0h waddr=%0h wdata=%0h want 1/f/c", bus.wen, bus.waddr, bus.wdata);
        end
        checks++; if (bus.ldm_done !== 1'b1 || bus.ldm_busy !== 1'b1 || bus.ldm_count !== 6'd3) begin
            failures++; $display("FAIL ldm_done: got done=%0h busy=%0h count=%0d want 1/1/3", bus.ldm_done, bus.ldm_busy, bus.ldm_count);
        end
        bus.ldm_dvalid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b0) begin failures++; $display("FAIL ldm_done_alu_ready: got %0h want 0", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.ldm_done !== 1'b0 || bus.ldm_busy !== 1'b0 || bus.ldm_count !== 6'd3 || bus.wen !== 1'b0) begin
            failures++; $display("FAIL ldm_exit: got done=%0h busy=%0h count=%0d wen=%0h want 0/0/3/0", bus.ldm_done, bus.ldm_busy, bus.ldm_count, bus.wen);
        end
    endtask

    task automatic test_ldm_zero();
        idle_inputs();
        bus.ldm_start = 1'b1; bus.ldm_mask = '0;
        tick();
        checks++; if (bus.ldm_busy !== 1'b1 || bus.wen !== 1'b0) begin
            failures++; $display("FAIL zero_enter: got busy=%0h wen=%0h want 1/0", bus.ldm_busy, bus.wen);
        end
        bus.ldm_start = 1'b0; bus.ldm_dvalid = 1'b1; bus.ldm_data = 32'h77;
        #1;
        checks++; if (bus.ldm_dready !== 1'b0) begin failures++; $display("FAIL zero_dready: got %0h want 0", bus.ldm_dready); end
        tick();
        checks++; if (bus.ldm_done !== 1'b1 || bus.wen !== 1'b0 || bus.ldm_count !== 6'd0) begin
            failures++; $display("FAIL zero_done: got done=%0h wen=%0h count=%0d want 1/0/0", bus.ldm_done, bus.wen, bus.ldm_count);
        end
        bus.ldm_dvalid = 1'b0;
        tick();
        checks++; if (bus.ldm_busy !== 1'b0 || bus.ldm_done !== 1'b0 || bus.wen !== 1'b0) begin
            failures++; $display("FAIL zero_exit: got busy=%0h done=%0h wen=%0h want 0/0/0", bus.ldm_busy, bus.ldm_done, bus.wen);
        end
    endtask

    task automatic test_reset_mid_ldm();
        idle_inputs();
        bus.ldm_start = 1'b1; bus.ldm_mask = 32'h0000_000F;
        tick();
        bus.ldm_start = 1'b0; bus.ldm_dvalid = 1'b1; bus.ldm_data = 32'h100;
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd0 || bus.wdata !== 32'h100) begin
            failures++; $display("FAIL abort_w0: got wen=%0h waddr=%0h wdata=%0h want 1/0/100", bus.wen, bus.waddr, bus.wdata);
        end
        bus.ldm_data = 32'h101;
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd1 || bus.ldm_count !== 6'd2) begin
            failures++; $display("FAIL abort_w1: got wen=%0h waddr=%0h count=%0d want 1/1/2", bus.wen, bus.waddr, bus.ldm_count);
        end
        bus.ldm_data = 32'h102;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.ldm_busy !== 1'b0 || bus.ldm_done !== 1'b0 || bus.wen !== 1'b0 || bus.ldm_count !== 6'd0) begin
            failures++; $display("FAIL abort_rst: got busy=%0h done=%0h wen=%0h count=%0d want 0/0/0/0", bus.ldm_busy, bus.ldm_done, bus.wen, bus.ldm_count);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.wen !== 1'b0 || bus.ldm_done !== 1'b0 || bus.ldm_busy !== 1'b0) begin
                failures++; $display("FAIL abort_quiet%0d: got wen=%0h done=%0h busy=%0h want 0/0/0", i, bus.wen, bus.ldm_done, bus.ldm_busy);
            end
        end
        bus.ldm_dvalid = 1'b0; bus.ldm_start = 1'b1; bus.ldm_mask = 32'h0000_0003;
        tick();
        checks++; if (bus.ldm_busy !== 1'b1 || bus.ldm_count !== 6'd0) begin
            failures++; $display("FAIL restart_enter: got busy=%0h count=%0d want 1/0", bus.ldm_busy, bus.ldm_count);
        end
        bus.ldm_start = 1'b0; bus.ldm_dvalid = 1'b1; bus.ldm_data = 32'h200;
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd0 || bus.wdata !== 32'h200) begin
            failures++; $display("FAIL restart_w0: got wen=%0h waddr=%0h wdata=%0h want 1/0/200", bus.wen, bus.waddr, bus.wdata);
        end
        bus.ldm_data = 32'h201;
        tick();
        checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd1 || bus.wdata !== 32'h201 || bus.ldm_done !== 1'b1 || bus.ldm_count !== 6'd2) begin
            failures++; $display("FAIL restart_w1: got wen=%0h waddr=%0h wdata=%0h done=%0h count=%0d want 1/1/201/1/2", bus.wen, bus.waddr, bus.wdata, bus.ldm_done, bus.ldm_count);
        end
        bus.ldm_dvalid = 1'b0;
        tick();
    endtask

    // Reference model: mode 0 = idle, 1 = loading, 2 = finishing. Pending LDM
    // destinations are kept as an ascending list of register numbers.
    task automatic test_random();
        int                mode;
        int                targets[$];
        logic [5:0]        cnt_m;
        logic              exp_wen;
        logic [ADDR_W-1:0] exp_waddr;
        logic [DATA_W-1:0] exp_wdata;
        logic              exp_alu_rdy, exp_mem_rdy, exp_d_rdy;
        int                sel;
        logic [31:0]       m;

        idle_inputs();
        rst = 1'b1;
        #3 rst = 1'b0;
        tick();
        mode = 0; cnt_m = '0; exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;

        for (int cyc = 0; cyc < 2500; cyc++) begin
            checks++; if (bus.wen !== exp_wen) begin failures++; $display("FAIL rand_wen c%0d: got %0h want %0h", cyc, bus.wen, exp_wen); end
            if (exp_wen) begin
                checks++; if (bus.waddr !== exp_waddr || bus.wdata !== exp_wdata) begin
                    failures++; $display("FAIL rand_write c%0d: got %0h/%0h want %0h/%0h", cyc, bus.waddr, bus.wdata, exp_waddr, exp_wdata);
                end
            end
            checks++; if (bus.ldm_busy !== (mode != 0) || bus.ldm_done !== (mode == 2) || bus.ldm_count !== cnt_m) begin
                failures++; $display("FAIL rand_status c%0d: got busy=%0h done=%0h count=%0d want %0h/%0h/%0d", cyc, bus.ldm_busy, bus.ldm_done, bus.ldm_count, (mode != 0), (mode == 2), cnt_m);
            end

            bus.alu_valid  = ($urandom_range(0, 2) == 0);
            bus.alu_waddr  = ADDR_W'($urandom);
            bus.alu_wdata  = $urandom;
            bus.mem_valid  = ($urandom_range(0, 3) == 0);
            bus.mem_waddr  = ADDR_W'($urandom);
            bus.mem_wdata  = $urandom;
            bus.ldm_start  = ($urandom_range(0, 5) == 0);
            sel = $urandom_range(0, 7);
            m   = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : ($urandom & $urandom);
            bus.ldm_mask   = m;
            bus.ldm_dvalid = ($urandom_range(0, 2) != 0);
            bus.ldm_data   = $urandom;

            exp_mem_rdy = (mode == 0);
            exp_alu_rdy = (mode == 0) && !bus.mem_valid;
            exp_d_rdy   = (mode == 1) && (targets.size() != 0);
            #1;
            checks++; if (bus.alu_ready !== exp_alu_rdy || bus.mem_ready !== exp_mem_rdy || bus.ldm_dready !== exp_d_rdy) begin
                failures++; $display("FAIL rand_ready c%0d: got alu=%0h mem=%0h d=%0h want %0h/%0h/%0h", cyc, bus.alu_ready, bus.mem_ready, bus.ldm_dready, exp_alu_rdy, exp_mem_rdy, exp_d_rdy);
            end

            exp_wen = 1'b0;
            if (mode == 0) begin
                if (bus.mem_valid) begin
                    exp_wen = 1'b1; exp_waddr = bus.mem_waddr; exp_wdata = bus.mem_wdata;
                end else if (bus.alu_valid) begin
                    exp_wen = 1'b1; exp_waddr = bus.alu_waddr; exp_wdata = bus.alu_wdata;
                end
                if (bus.ldm_start) begin
                    targets.delete();
                    for (int b = 0; b < 32; b++) if (m[b]) targets.push_back(b);
                    cnt_m = '0;
                    mode  = 1;
                end
            end else if (mode == 1) begin
                if (targets.size() == 0) begin
                    mode = 2;
                end else if (bus.ldm_dvalid) begin
                    exp_wen   = 1'b1;
                    exp_waddr = ADDR_W'(targets.pop_front());
                    exp_wdata = bus.ldm_data;
                    cnt_m     = cnt_m + 6'd1;
                    if (targets.size() == 0) mode = 2;
                end
            end else begin
                mode = 0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_single();
        test_priority();
        test_ldm_stall();
        test_ldm_zero();
        test_reset_mid_ldm();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1);
    end

endmodule

// File: doc/v60_wb_arbiter.md
Name: v60_wb_arbiter

Overview:
- Writeback stage directly upstream of the V60 register file. Owns the file's single write port (waddr/wdata/wen).
- Merges single-cycle ALU results and memory-load results, plus multi-register load sequences (LDM-style, driven by a 32-bit register mask), into at most one register write per cycle.
- All write-port outputs are registered.

Parameters:
- NUM_REGS, 32, number of architectural registers; mask width.
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; must equal clog2(NUM_REGS).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when valid&ready.
- alu_waddr  in  ADDR_W  ALU destination register.
- alu_wdata  in  DATA_W  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load accepted when valid&ready.
- mem_waddr  in  ADDR_W  load destination register.
- mem_wdata  in  DATA_W  load data.
- ldm_start  in  1  start multi-register load; sampled only in IDLE.
- ldm_mask  in  NUM_REGS  bit i set = register i is written.
- ldm_dvalid  in  1  next LDM data word offered.
- ldm_dready  out  1  LDM word accepted when dvalid&dready.
- ldm_data  in  DATA_W  LDM data word.
- ldm_busy  out  1  sequence in progress.
- ldm_done  out  1  one-cycle pulse when sequence completes.
- ldm_count  out  6  writes issued by the current/last sequence.
- waddr  out  ADDR_W  to regfile write address.
- wdata  out  DATA_W  to regfile write data.
- wen  out  1  to regfile write enable.

Behaviour:
- Reset (async, while rst=1):
  - waddr=0, wdata=0, wen=0.
  - ldm_busy=0, ldm_done=0, ldm_count=0.
  - Internal mask cleared; state=IDLE.
  - Any in-flight sequence is abandoned with no done pulse.
- States: IDLE, LDM, DONE.
- IDLE handshakes:
  - mem_ready = 1.
  - alu_ready = !mem_valid. Memory has priority; an ALU result waits while mem_valid is high.
  - ldm_dready = 0.
- Latency: an accepted beat produces wen=1 with that waddr/wdata on the next cycle. Exactly one cycle, no buffering.
- wen is 0 in any cycle following a cycle with no accepted beat.
- IDLE with ldm_start=1:
  - Latch ldm_mask; clear ldm_count; next state LDM.
  - ldm_busy=1 from the next cycle.
  - An ALU/mem beat accepted in the same start cycle is still written on the following cycle, before any LDM write.
- LDM handshakes: alu_ready=0, mem_ready=0, ldm_start ignored, ldm_dready=1.
- LDM beat (dvalid&dready):
  - Target = lowest set bit of the latched mask.
  - Next cycle: wen=1, waddr=target, wdata=ldm_data.
  - Clear that mask bit; ldm_count increments.
- ldm_dvalid=0 in LDM stalls the sequence: no write, state held.
- Mask exhaustion: when the accepted beat clears the last set bit, next state is DONE.
- Zero mask: latched mask of 0 goes LDM→DONE with no write and no data accepted (ldm_dready=0 in that cycle).
- DONE (one cycle):
  - ldm_done=1, ldm_busy=1, no handshakes accepted.
  - The final LDM write's wen is coincident with DONE.
  - Next state IDLE; ldm_busy=0 thereafter.
- ldm_count holds its final value until the next ldm_start.
- Maximum 32 writes per sequence, so the 6-bit counter never wraps.
- Duplicate waddr across consecutive writes is legal. Ordering is strictly acceptance order.

Test Plan:
- Reset asserted mid-cycle with alu_valid=1 -> wen=0, waddr=0, ldm_busy=0 immediately (async). After release, the first accepted beat writes normally.
- alu_valid=1, waddr=3, wdata=0xDEADBEEF, mem_valid=0 -> alu_ready=1; next cycle wen=1, waddr=3, wdata=0xDEADBEEF; following cycle wen=0.
- alu (r4=0x1111) and mem (r7=0x2222) valid together -> cycle0 mem accepted with alu_ready=0; cycle1 write r7=0x2222 and alu accepted; cycle2 write r4=0x1111.
- ldm_start with mask=0x00008005; data 0xA, 0xB, 0xC; dvalid low for one cycle between 0xA and 0xB -> writes r0=0xA, r2=0xB, r15=0xC; no write in the stall; ldm_done pulses once, coincident with the r15 write; ldm_count=3; alu_ready=0 throughout busy.
- ldm_start with mask=0 -> LDM then DONE with no wen and ldm_dready=0; ldm_done pulse; ldm_count=0; IDLE after.
- rst pulsed after the 2nd of 4 LDM beats (mask=0x0000000F) -> busy drops, no done pulse, remaining registers not written. A new ldm_start after reset begins cleanly with ldm_count=0.
